// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Default operand/result width in bits
    localparam int DEFAULT_WIDTH = 8;

    // Sequencer states of the serial subtractor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_arith_pkg

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit subtract cell, d = x - y - b_in with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    // Difference bit and borrow generated by this bit position
    always_comb begin
        d     = x ^ y ^ b_in;
        b_out = (~x & y) | (~(x ^ y) & b_in);
    end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a-b one bit per clock, LSB first, using a single
// full_subtractor cell. Defining SERIAL_SUB_OVF_EN adds the signed-overflow
// output ovf; without it the block has no ovf port and no overflow logic.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             last_bit;
    logic             cell_d;
    logic             cell_b_out;

    assign accept   = start_valid && start_ready;
    assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

    full_subtractor u_cell (
        .x     (a_q[0]),
        .y     (b_q[0]),
        .b_in  (br_q),
        .d     (cell_d),
        .b_out (cell_b_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on the last bit, DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (last_bit)    state_d = DONE;
            DONE:                     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE:    start_ready = 1'b1;
            RUN:     busy        = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Datapath next state: capture on accept, shift one bit per RUN cycle, hold otherwise
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        diff_d = diff_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            br_d  = 1'b0;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d    = {1'b0, a_q[WIDTH-1:1]};
            b_d    = {1'b0, b_q[WIDTH-1:1]};
            // New bit enters at the MSB so the word is aligned after WIDTH shifts
            diff_d = {cell_d, diff_q[WIDTH-1:1]};
            br_d   = cell_b_out;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; results are cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            diff_q <= diff_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = br_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // Operand sign bits are kept aside because the shift registers lose them
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end else if (last_bit) begin
            // cell_d is the result MSB on the last bit
            ovf_d = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end
    end

    // Overflow registers, updated alongside the final diff bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors, reset-abort sequence and random
// operands against an arithmetic reference model, for WIDTH = 8.
module tb_serial_subtractor;

    localparam int WIDTH    = 8;
    localparam int WAIT_MAX = 40;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .diff        (diff),
        .borrow_out  (borrow_out),
        .busy        (busy),
        .done        (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic void model(input logic [7:0] av, input logic [7:0] bv,
                                  output logic [7:0] ed, output logic eb, output logic eo);
        int sa, sb, r;
        ed = av - bv;
        eb = (av < bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        r  = sa - sb;
        eo = (r > 127) || (r < -128);
    endfunction

    // One complete request. When disturb is set, start_valid stays high through
    // the run and a/b are scrambled a few cycles after capture.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb,
                          input bit disturb, input string nm, output logic ovf_obs);
        int n;
        bit seen;
        bit ready_ok;
        a = av;
        b = bv;
        start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < WAIT_MAX) begin
            @(posedge clk); #1; n++;
        end
        check({nm, "_ready_before"}, 32'(start_ready), 32'd1);
        @(posedge clk); #1;                       // accept edge
        if (!disturb) start_valid = 1'b0;
        ready_ok = !start_ready && busy && !done;
        n = 0;
        seen = 1'b0;
        while (!seen && n < WAIT_MAX) begin
            if (disturb && n == 3) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(posedge clk); #1; n++;
            if (start_ready || !busy) ready_ok = 1'b0;
            if (done) seen = 1'b1;
        end
        // done is high in the cycle ending at the (WIDTH+1)-th edge after accept,
        // i.e. it is first seen just after the WIDTH-th edge.
        check({nm, "_done_seen"}, 32'(seen), 32'd1);
        check({nm, "_latency"}, 32'(n), 32'(WIDTH));
        check({nm, "_ready_low_run"}, 32'(ready_ok), 32'd1);
        check({nm, "_diff"}, 32'(diff), 32'(ed));
        check({nm, "_borrow"}, 32'(borrow_out), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        ovf_obs = ovf;
`else
        ovf_obs = 1'b0;
`endif
        start_valid = 1'b0;
        @(posedge clk); #1;
        check({nm, "_idle_after"}, {29'd0, start_ready, busy, done}, 32'b100);
        check({nm, "_diff_held"}, 32'(diff), 32'(ed));
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       ov;
        bit         disturb;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic       ovf_obs;
        logic [7:0] ra, rb, ed;
        logic       eb, eo;
        bit         no_done;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h40, 8'hC0, 8'h80, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b1;
        start_valid = 1'b0;
        a = '0;
        b = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_ready", 32'(start_ready), 32'd1);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; entries 2 and 3 run back to back
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].disturb,
                   $sformatf("vec%0d", i), ovf_obs);
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(ovf_obs), 32'(vecs[i].ov));
`endif
        end

        // Reset while bit 4 is being processed: abandon the run, no done afterwards
        a = 8'h5A;
        b = 8'h33;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(start_ready), 32'd1);
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", 32'(ovf), 32'd0);
`endif
        no_done = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) no_done = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 3) begin
            @(posedge clk); #1;
            if (done) no_done = 1'b0;
        end
        check("abort_no_done", 32'(no_done), 32'd1);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "after_abort", ovf_obs);

        // Random operands against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(ra, rb, ed, eb, eo);
            run_op(ra, rb, ed, eb, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i), ovf_obs);
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("rnd%0d_ovf", i), 32'(ovf_obs), 32'(eo));
`endif
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_serial_subtractor
